// File: rtl/frame_cmd_ctrl.sv
// frame_cmd_ctrl: decodes the byte-oriented command frames arriving from the
// UART receiver, drives register-file writes/reads and ALU starts, and pushes
// response bytes into the TX FIFO. Every output is registered; strobes are
// one-cycle pulses appearing the cycle after their triggering input.
module frame_cmd_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int FUNC_WIDTH   = 4,
   parameter int WAIT_TIMEOUT = 15
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   rx_data,
   input  logic                    rx_valid,
   input  logic [DATA_WIDTH-1:0]   rf_rd_data,
   input  logic                    rf_rd_valid,
   input  logic [2*DATA_WIDTH-1:0] alu_out,
   input  logic                    alu_out_valid,
   input  logic                    fifo_full,
   output logic [ADDR_WIDTH-1:0]   rf_addr,
   output logic                    rf_wr_en,
   output logic [DATA_WIDTH-1:0]   rf_wr_data,
   output logic                    rf_rd_en,
   output logic                    alu_en,
   output logic [FUNC_WIDTH-1:0]   alu_fun,
   output logic                    clk_gate_en,
   output logic [DATA_WIDTH-1:0]   fifo_wr_data,
   output logic                    fifo_wr_inc,
   output logic                    cmd_error
);

   localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

   localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ANS = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
      FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CNT_W-1:0]          r_wait_cnt;
   logic [CNT_W-1:0]          w_wait_cnt;
   logic [DATA_WIDTH-1:0]     r_rd_byte;
   logic [DATA_WIDTH-1:0]     w_rd_byte;
   logic [2*DATA_WIDTH-1:0]   r_alu_res;
   logic [2*DATA_WIDTH-1:0]   w_alu_res;

   logic [ADDR_WIDTH-1:0]     w_rf_addr;
   logic                      w_rf_wr_en;
   logic [DATA_WIDTH-1:0]     w_rf_wr_data;
   logic                      w_rf_rd_en;
   logic                      w_alu_en;
   logic [FUNC_WIDTH-1:0]     w_alu_fun;
   logic                      w_clk_gate_en;
   logic [DATA_WIDTH-1:0]     w_fifo_wr_data;
   logic                      w_fifo_wr_inc;
   logic                      w_cmd_error;

   // State register; reset drops any partially received frame.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode plus next values for every registered output.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt     = '0;
      w_rd_byte      = r_rd_byte;
      w_alu_res      = r_alu_res;
      w_rf_addr      = rf_addr;
      w_rf_wr_en     = 1'b0;
      w_rf_wr_data   = rf_wr_data;
      w_rf_rd_en     = 1'b0;
      w_alu_en       = 1'b0;
      w_alu_fun      = alu_fun;
      w_fifo_wr_data = fifo_wr_data;
      w_fifo_wr_inc  = 1'b0;
      w_cmd_error    = 1'b0;
      w_clk_gate_en  = 1'b0;

      case (r_state)
         IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  CMD_WR:  w_state_nxt = WR_ADDR;
                  CMD_RD:  w_state_nxt = RD_ADDR;
                  CMD_ALU: w_state_nxt = OP_A;
                  CMD_ANS: w_state_nxt = FUN;
                  default: w_cmd_error = 1'b1;
               endcase
            end
         end
         WR_ADDR: begin
            if (rx_valid) begin
               w_rf_addr   = rx_data[ADDR_WIDTH-1:0];
               w_state_nxt = WR_DATA;
            end
         end
         WR_DATA: begin
            if (rx_valid) begin
               w_rf_wr_en   = 1'b1;
               w_rf_wr_data = rx_data;
               w_state_nxt  = IDLE;
            end
         end
         RD_ADDR: begin
            if (rx_valid) begin
               w_rf_rd_en  = 1'b1;
               w_rf_addr   = rx_data[ADDR_WIDTH-1:0];
               w_state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // A stray byte is dropped even when the read data lands together.
            w_cmd_error = rx_valid;
            if (rf_rd_valid) begin
               w_rd_byte   = rf_rd_data;
               w_state_nxt = TX_RD;
            end else if (r_wait_cnt == CNT_LAST) begin
               w_cmd_error = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_wait_cnt = r_wait_cnt + CNT_W'(1);
            end
         end
         OP_A: begin
            if (rx_valid) begin
               w_rf_wr_en   = 1'b1;
               w_rf_addr    = ADDR_WIDTH'(0);
               w_rf_wr_data = rx_data;
               w_state_nxt  = OP_B;
            end
         end
         OP_B: begin
            if (rx_valid) begin
               w_rf_wr_en   = 1'b1;
               w_rf_addr    = ADDR_WIDTH'(1);
               w_rf_wr_data = rx_data;
               w_state_nxt  = FUN;
            end
         end
         FUN: begin
            if (rx_valid) begin
               w_alu_fun   = rx_data[FUNC_WIDTH-1:0];
               w_alu_en    = 1'b1;
               w_state_nxt = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            w_cmd_error = rx_valid;
            if (alu_out_valid) begin
               w_alu_res   = alu_out;
               w_state_nxt = TX_LO;
            end else if (r_wait_cnt == CNT_LAST) begin
               w_cmd_error = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_wait_cnt = r_wait_cnt + CNT_W'(1);
            end
         end
         TX_RD: begin
            w_cmd_error = rx_valid;
            if (!fifo_full) begin
               w_fifo_wr_data = r_rd_byte;
               w_fifo_wr_inc  = 1'b1;
               w_state_nxt    = IDLE;
            end
         end
         TX_LO: begin
            w_cmd_error = rx_valid;
            if (!fifo_full) begin
               w_fifo_wr_data = r_alu_res[DATA_WIDTH-1:0];
               w_fifo_wr_inc  = 1'b1;
               w_state_nxt    = TX_HI;
            end
         end
         TX_HI: begin
            w_cmd_error = rx_valid;
            if (!fifo_full) begin
               w_fifo_wr_data = r_alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
               w_fifo_wr_inc  = 1'b1;
               w_state_nxt    = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // ALU clock runs from FUN entry until its result (or a timeout) arrives.
      w_clk_gate_en = (w_state_nxt == FUN) || (w_state_nxt == ALU_WAIT);
   end

   // Output, capture and wait-counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wait_cnt   <= '0;
         r_rd_byte    <= '0;
         r_alu_res    <= '0;
         rf_addr      <= '0;
         rf_wr_en     <= 1'b0;
         rf_wr_data   <= '0;
         rf_rd_en     <= 1'b0;
         alu_en       <= 1'b0;
         alu_fun      <= '0;
         clk_gate_en  <= 1'b0;
         fifo_wr_data <= '0;
         fifo_wr_inc  <= 1'b0;
         cmd_error    <= 1'b0;
      end else begin
         r_wait_cnt   <= w_wait_cnt;
         r_rd_byte    <= w_rd_byte;
         r_alu_res    <= w_alu_res;
         rf_addr      <= w_rf_addr;
         rf_wr_en     <= w_rf_wr_en;
         rf_wr_data   <= w_rf_wr_data;
         rf_rd_en     <= w_rf_rd_en;
         alu_en       <= w_alu_en;
         alu_fun      <= w_alu_fun;
         clk_gate_en  <= w_clk_gate_en;
         fifo_wr_data <= w_fifo_wr_data;
         fifo_wr_inc  <= w_fifo_wr_inc;
         cmd_error    <= w_cmd_error;
      end
   end

endmodule

// File: tb/tb_frame_cmd_ctrl.sv
// Directed, table-driven bench for frame_cmd_ctrl. Each table row is one
// clock cycle: inputs driven at the falling edge, registered outputs checked
// just after the following rising edge.
module tb_frame_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rf_rd_data = '0;
   logic        rf_rd_valid = 1'b0;
   logic [15:0] alu_out = '0;
   logic        alu_out_valid = 1'b0;
   logic        fifo_full = 1'b0;
   logic [3:0]  rf_addr;
   logic        rf_wr_en;
   logic [7:0]  rf_wr_data;
   logic        rf_rd_en;
   logic        alu_en;
   logic [3:0]  alu_fun;
   logic        clk_gate_en;
   logic [7:0]  fifo_wr_data;
   logic        fifo_wr_inc;
   logic        cmd_error;

   int checks = 0;
   int failures = 0;

   frame_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUNC_WIDTH(4), .WAIT_TIMEOUT(15)) dut (
      .CLK(CLK), .RST(RST),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
      .alu_out(alu_out), .alu_out_valid(alu_out_valid),
      .fifo_full(fifo_full),
      .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
      .rf_rd_en(rf_rd_en), .alu_en(alu_en), .alu_fun(alu_fun),
      .clk_gate_en(clk_gate_en), .fifo_wr_data(fifo_wr_data),
      .fifo_wr_inc(fifo_wr_inc), .cmd_error(cmd_error)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rxv;  logic [7:0]  rxd;
      logic        rdv;  logic [7:0]  rdd;
      logic        aluv; logic [15:0] alu;
      logic        full;
      logic [3:0]  e_addr; logic e_wr; logic [7:0] e_wd; logic e_rd;
      logic        e_aen;  logic [3:0] e_fun; logic e_cg;
      logic [7:0]  e_fd;   logic e_inc; logic e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rxv, input logic [7:0] rxd,
                               input logic rdv, input logic [7:0] rdd,
                               input logic aluv, input logic [15:0] alu,
                               input logic full,
                               input logic [3:0] ea, input logic ew, input logic [7:0] ewd,
                               input logic er, input logic eaen, input logic [3:0] efun,
                               input logic ecg, input logic [7:0] efd, input logic einc,
                               input logic eerr);
      vec_t v;
      v.rxv = rxv; v.rxd = rxd; v.rdv = rdv; v.rdd = rdd;
      v.aluv = aluv; v.alu = alu; v.full = full;
      v.e_addr = ea; v.e_wr = ew; v.e_wd = ewd; v.e_rd = er;
      v.e_aen = eaen; v.e_fun = efun; v.e_cg = ecg;
      v.e_fd = efd; v.e_inc = einc; v.e_err = eerr;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic check_outs(input int idx, input logic [3:0] ea, input logic ew, input logic [7:0] ewd,
                             input logic er, input logic eaen, input logic [3:0] efun,
                             input logic ecg, input logic [7:0] efd, input logic einc,
                             input logic eerr);
      chk("rf_addr",      idx, {12'd0, rf_addr},      {12'd0, ea});
      chk("rf_wr_en",     idx, {15'd0, rf_wr_en},     {15'd0, ew});
      chk("rf_wr_data",   idx, {8'd0, rf_wr_data},    {8'd0, ewd});
      chk("rf_rd_en",     idx, {15'd0, rf_rd_en},     {15'd0, er});
      chk("alu_en",       idx, {15'd0, alu_en},       {15'd0, eaen});
      chk("alu_fun",      idx, {12'd0, alu_fun},      {12'd0, efun});
      chk("clk_gate_en",  idx, {15'd0, clk_gate_en},  {15'd0, ecg});
      chk("fifo_wr_data", idx, {8'd0, fifo_wr_data},  {8'd0, efd});
      chk("fifo_wr_inc",  idx, {15'd0, fifo_wr_inc},  {15'd0, einc});
      chk("cmd_error",    idx, {15'd0, cmd_error},    {15'd0, eerr});
   endtask

   task automatic drive(input logic rxv, input logic [7:0] rxd, input logic rdv, input logic [7:0] rdd,
                        input logic aluv, input logic [15:0] alu, input logic full);
      @(negedge CLK);
      rx_valid = rxv; rx_data = rxd; rf_rd_valid = rdv; rf_rd_data = rdd;
      alu_out_valid = aluv; alu_out = alu; fifo_full = full;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // ---------------- table: register write / read ----------------
      //   rxv rxd    rdv rdd    aluv alu      full | addr wr wd     rd aen fun cg fd     inc err
      add(1, 8'hAA, 0, 8'h00, 0, 16'h0000, 0,  4'd0, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      add(1, 8'h05, 0, 8'h00, 0, 16'h0000, 0,  4'd5, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      add(1, 8'h55, 0, 8'h00, 0, 16'h0000, 0,  4'd5, 1, 8'h55, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd5, 0, 8'h55, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      add(1, 8'hBB, 0, 8'h00, 0, 16'h0000, 0,  4'd5, 0, 8'h55, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      add(1, 8'h05, 0, 8'h00, 0, 16'h0000, 0,  4'd5, 0, 8'h55, 1, 0, 4'd0, 0, 8'h00, 0, 0);
      add(0, 8'h00, 1, 8'h55, 0, 16'h0000, 0,  4'd5, 0, 8'h55, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd5, 0, 8'h55, 0, 0, 4'd0, 0, 8'h55, 1, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd5, 0, 8'h55, 0, 0, 4'd0, 0, 8'h55, 0, 0);
      // ---------------- ALU with new operands: CC 0A 19 00 ----------------
      add(1, 8'hCC, 0, 8'h00, 0, 16'h0000, 0,  4'd5, 0, 8'h55, 0, 0, 4'd0, 0, 8'h55, 0, 0);
      add(1, 8'h0A, 0, 8'h00, 0, 16'h0000, 0,  4'd0, 1, 8'h0A, 0, 0, 4'd0, 0, 8'h55, 0, 0);
      add(1, 8'h19, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 1, 8'h19, 0, 0, 4'd0, 1, 8'h55, 0, 0);
      add(1, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 1, 4'd0, 1, 8'h55, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd0, 1, 8'h55, 0, 0);
      add(0, 8'h00, 0, 8'h00, 1, 16'h0023, 0,  4'd1, 0, 8'h19, 0, 0, 4'd0, 0, 8'h55, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd0, 0, 8'h23, 1, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd0, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      // ---------------- stored-operand ALU DD 06 with 10 cycles of full FIFO ----------------
      add(1, 8'hDD, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd0, 1, 8'h00, 0, 0);
      add(1, 8'h06, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 1, 4'd6, 1, 8'h00, 0, 0);
      add(0, 8'h00, 0, 8'h00, 1, 16'h00FB, 0,  4'd1, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 0);
      add(1, 8'h77, 0, 8'h00, 0, 16'h0000, 1,  4'd1, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 1);
      for (int i = 0; i < 9; i++)
         add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1, 4'd1, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd6, 0, 8'hFB, 1, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 0);
      // ---------------- unknown command, then read timeout ----------------
      add(1, 8'h3C, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 1);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 0);
      add(1, 8'hBB, 0, 8'h00, 0, 16'h0000, 0,  4'd1, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 0);
      add(1, 8'h07, 0, 8'h00, 0, 16'h0000, 0,  4'd7, 0, 8'h19, 1, 0, 4'd6, 0, 8'h00, 0, 0);
      for (int i = 0; i < 14; i++)
         add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 4'd7, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd7, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 1);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd7, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 0);
      // ---------------- stray byte arriving together with read data ----------------
      add(1, 8'hBB, 0, 8'h00, 0, 16'h0000, 0,  4'd7, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 0);
      add(1, 8'h03, 0, 8'h00, 0, 16'h0000, 0,  4'd3, 0, 8'h19, 1, 0, 4'd6, 0, 8'h00, 0, 0);
      add(1, 8'h99, 1, 8'h3C, 0, 16'h0000, 0,  4'd3, 0, 8'h19, 0, 0, 4'd6, 0, 8'h00, 0, 1);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd3, 0, 8'h19, 0, 0, 4'd6, 0, 8'h3C, 1, 0);
      add(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  4'd3, 0, 8'h19, 0, 0, 4'd6, 0, 8'h3C, 0, 0);

      // ---------------- reset state ----------------
      repeat (2) @(posedge CLK);
      #1;
      check_outs(-1, 4'd0, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      @(negedge CLK);
      RST = 1'b0;

      // ---------------- table run ----------------
      foreach (vecs[i]) begin
         drive(vecs[i].rxv, vecs[i].rxd, vecs[i].rdv, vecs[i].rdd,
               vecs[i].aluv, vecs[i].alu, vecs[i].full);
         check_outs(i, vecs[i].e_addr, vecs[i].e_wr, vecs[i].e_wd, vecs[i].e_rd,
                    vecs[i].e_aen, vecs[i].e_fun, vecs[i].e_cg, vecs[i].e_fd,
                    vecs[i].e_inc, vecs[i].e_err);
      end

      // ---------------- reset mid-frame: AA 05 <reset> 55 ----------------
      drive(1, 8'hAA, 0, 8'h00, 0, 16'h0000, 0);
      drive(1, 8'h05, 0, 8'h00, 0, 16'h0000, 0);
      chk("addr_before_rst", 100, {12'd0, rf_addr}, 16'h0005);
      @(negedge CLK);
      rx_valid = 1'b0;
      RST = 1'b1;
      #1;
      check_outs(101, 4'd0, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0);
         check_outs(102 + i, 4'd0, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 0, 0);
      end
      drive(1, 8'h55, 0, 8'h00, 0, 16'h0000, 0);
      check_outs(105, 4'd0, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 0, 1);
      drive(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0);
      check_outs(106, 4'd0, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_cmd_ctrl.md
Name: frame_cmd_ctrl

Overview:
- Command sequencer between the UART RX byte stream and the shared register file, ALU and TX FIFO of the system top, in the reference-clock domain.
- Decodes the frame protocol, sequences register-file and ALU accesses, and pushes response bytes into the TX FIFO:
  - AA addr data: register write.
  - BB addr: register read.
  - CC A B fun: ALU operation with new operands.
  - DD fun: ALU operation on stored REG0/REG1.

Parameters:
DATA_WIDTH, 8, width of UART bytes, register-file data and FIFO data.
ADDR_WIDTH, 4, register-file address width.
FUNC_WIDTH, 4, ALU function code width.
WAIT_TIMEOUT, 15, maximum cycles to wait for rf_rd_valid / alu_out_valid before aborting.

Ports:
CLK  in  1  reference clock.
RST  in  1  asynchronous reset, active-high.
rx_data  in  DATA_WIDTH  received byte, valid with rx_valid.
rx_valid  in  1  one-cycle pulse per received byte.
rf_rd_data  in  DATA_WIDTH  register-file read data.
rf_rd_valid  in  1  read data valid pulse.
alu_out  in  2*DATA_WIDTH  ALU result.
alu_out_valid  in  1  ALU result valid pulse.
fifo_full  in  1  TX FIFO full.
rf_addr  out  ADDR_WIDTH  register-file address.
rf_wr_en  out  1  write strobe.
rf_wr_data  out  DATA_WIDTH  write data.
rf_rd_en  out  1  read strobe.
alu_en  out  1  ALU start strobe.
alu_fun  out  FUNC_WIDTH  ALU function code.
clk_gate_en  out  1  ALU clock-gate enable.
fifo_wr_data  out  DATA_WIDTH  byte pushed to TX FIFO.
fifo_wr_inc  out  1  FIFO push strobe.
cmd_error  out  1  one-cycle pulse: unknown command, unexpected byte, or timeout.

Behaviour:
- Output timing:
  - All outputs are registered.
  - Strobes (rf_wr_en, rf_rd_en, alu_en, fifo_wr_inc, cmd_error) are single-cycle pulses, asserted the cycle after their triggering condition is sampled.
- Reset: state=IDLE and every output 0. Reset mid-frame discards the partial frame. No strobe is issued after RST deasserts until a new command byte arrives.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- IDLE, on rx_valid:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - 0xCC -> OP_A.
  - 0xDD -> FUN.
  - Any other byte: stay in IDLE, pulse cmd_error.
- WR_ADDR: on rx_valid latch rx_data[ADDR_WIDTH-1:0] -> WR_DATA.
- WR_DATA: on rx_valid issue rf_wr_en with the latched rf_addr and rf_wr_data=rx_data -> IDLE.
- RD_ADDR: on rx_valid issue rf_rd_en with rf_addr=rx_data[ADDR_WIDTH-1:0] -> RD_WAIT.
- RD_WAIT: on rf_rd_valid capture rf_rd_data -> TX_RD.
- TX_RD: when !fifo_full issue fifo_wr_inc with the captured byte -> IDLE.
- OP_A: on rx_valid write rx_data to address 0 -> OP_B.
- OP_B: on rx_valid write rx_data to address 1 -> FUN.
- FUN:
  - clk_gate_en=1.
  - On rx_valid latch alu_fun=rx_data[FUNC_WIDTH-1:0], issue alu_en -> ALU_WAIT.
- ALU_WAIT: clk_gate_en stays 1. On alu_out_valid capture alu_out, drop clk_gate_en -> TX_LO.
- TX_LO: when !fifo_full push alu_out[DATA_WIDTH-1:0] -> TX_HI.
- TX_HI: when !fifo_full push alu_out[2*DATA_WIDTH-1:DATA_WIDTH] -> IDLE.
- Full FIFO: the block stalls in the TX state with no push and no byte loss. It is the sole FIFO writer.
- Timeout: a wait counter runs in RD_WAIT/ALU_WAIT and clears on entry. Reaching WAIT_TIMEOUT cycles without a valid -> IDLE, cmd_error pulse, clk_gate_en=0.
- Unexpected bytes: rx_valid in RD_WAIT, ALU_WAIT or any TX state drops the byte and pulses cmd_error. The state is unchanged.
- Simultaneous events: when rx_valid and rf_rd_valid/alu_out_valid arrive in the same cycle, the valid is processed and the byte is dropped with cmd_error.
- rf_addr and alu_fun hold their last values between strobes.

Test Plan:
- Register write/read: AA,05,55 then BB,05 -> rf_wr_en with addr 5 / data 0x55; rf_rd_en addr 5; returned 0x55 pushed as one fifo_wr_inc.
- ALU with operands: CC,0A,19,00 with alu_out=0x0023 -> writes addr0=0x0A, addr1=0x19; alu_en with fun 0; FIFO receives 0x23 then 0x00; clk_gate_en high from FUN entry to alu_out_valid.
- Stored-operand ALU: DD,06 with alu_out=0x00FB -> no rf_wr_en; alu_en fun 6; pushes FB,00.
- Backpressure: fifo_full=1 for 10 cycles during TX_LO -> no push while full; both bytes pushed in order after release.
- Errors: byte 0x3C in IDLE -> cmd_error, state IDLE. RD_WAIT with no rf_rd_valid for 15 cycles -> cmd_error, return to IDLE, no FIFO push.
- Reset: RST asserted after AA,05 -> all outputs 0. A following 55 byte is treated as an unknown command (cmd_error), with no rf_wr_en.
